mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_defs.sv | 20 ++
 rtl/mult_seq_ctrl_adder.sv | 19 +
 rtl/mult_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mult_defs.sv
// Shared definitions for the iterative arithmetic sequencers.
// Holds the sequencer state encoding and the default iteration count so a
// future shift-subtract divider can reuse the same state names and widths.
package mult_defs;

    // One iteration per operand bit.
    localparam int MULT_ITERS_DEF = 32;
    localparam int DATA_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEG_A  = 3'd1,
        ST_NEG_B  = 3'd2,
        ST_ITER   = 3'd3,
        ST_NEG_LO = 3'd4,
        ST_NEG_HI = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/mult_seq_ctrl_adder.sv
// adder32bit: the single shared 32-bit ripple/carry adder.
// Ports:
//   a_i, b_i   32-bit operands
//   cin_i      carry in
//   sum_o      32-bit sum
//   cout_o     carry out
module adder32bit
    import mult_defs::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential shift-add multiplier for MULT / MULTU.
// Signed operands are made positive up front, the magnitudes are multiplied
// with MULT_ITERS shift-add steps, and the 64-bit result is negated at the end
// if the operand signs differed. Every addition goes through one adder32bit.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        request a multiply (only looked at in IDLE)
//   is_signed    1 = two's complement, 0 = unsigned; captured with start
//   op_a, op_b   multiplicand / multiplier; captured with start
//   busy         high whenever the sequencer is not IDLE
//   done         one-cycle pulse, hi/lo valid in that cycle
//   hi, lo       upper / lower product halves, held until the next start
module mult_seq_ctrl
    import mult_defs::*;
#(
    parameter int MULT_ITERS = MULT_ITERS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(MULT_ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_ITERS - 1);

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              signed_q;
    logic              neg_q;
    logic              carry_q;

    logic [DATA_W-1:0] add_a, add_b, add_sum;
    logic              add_cin, add_cout;

    // Operand/carry-in steering for the shared adder. Negations are
    // ~x + 0 + 1, except the upper half which takes the low-half carry.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            ST_NEG_A: begin
                add_a   = ~mcand_q;
                add_cin = 1'b1;
            end
            ST_NEG_B: begin
                add_a   = ~lo_q;
                add_cin = 1'b1;
            end
            ST_ITER: begin
                add_a = hi_q;
                add_b = lo_q[0] ? mcand_q : '0;
            end
            ST_NEG_LO: begin
                add_a   = ~lo_q;
                add_cin = 1'b1;
            end
            ST_NEG_HI: begin
                add_a   = ~hi_q;
                add_cin = carry_q;
            end
            default: ;
        endcase
    end

    adder32bit u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = is_signed ? ST_NEG_A : ST_ITER;
            ST_NEG_A:  state_d = ST_NEG_B;
            ST_NEG_B:  state_d = ST_ITER;
            ST_ITER:   if (cnt_q == CNT_LAST) state_d = signed_q ? ST_NEG_LO : ST_DONE;
            ST_NEG_LO: state_d = ST_NEG_HI;
            ST_NEG_HI: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mcand_q  <= op_a;
                        lo_q     <= op_b;
                        hi_q     <= '0;
                        cnt_q    <= '0;
                        carry_q  <= 1'b0;
                        signed_q <= is_signed;
                        neg_q    <= is_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                    end
                end
                // 0x80000000 negates to itself; ITER then treats it as 2^31.
                ST_NEG_A: if (mcand_q[DATA_W-1]) mcand_q <= add_sum;
                ST_NEG_B: if (lo_q[DATA_W-1]) lo_q <= add_sum;
                ST_ITER: begin
                    // Shift {carry, sum, lo} right by one: the product
                    // grows into hi while the multiplier drains out of lo.
                    hi_q  <= {add_cout, add_sum[DATA_W-1:1]};
                    lo_q  <= {add_sum[0], lo_q[DATA_W-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                end
                ST_NEG_LO: begin
                    if (neg_q) begin
                        lo_q    <= add_sum;
                        carry_q <= add_cout;
                    end
                end
                ST_NEG_HI: if (neg_q) hi_q <= add_sum;
                default: ;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_seq_ctrl #(.MULT_ITERS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          sgn;
        logic [31:0] a, b;
        logic [31:0] exp_hi, exp_lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference product from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_prod(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    // Must be entered just after a negedge. Start is sampled at the next
    // posedge (edge k); the i-th following negedge samples cycle k+i.
    task automatic run_op(input string name, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int restart_at);
        int          lat;
        int          first_done;
        int          ndone;
        int          busy_bad;
        logic [31:0] ghi, glo;
        lat        = sgn ? 37 : 33;
        first_done = -1;
        ndone      = 0;
        busy_bad   = 0;
        ghi        = '0;
        glo        = '0;
        start      = 1'b1;
        is_signed  = sgn;
        op_a       = a;
        op_b       = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        is_signed = 1'($urandom);
        for (int i = 1; i <= lat + 4; i++) begin
            @(negedge clk);
            if (restart_at != 0 && i == restart_at) begin
                start     = 1'b1;
                is_signed = 1'b0;
                op_a      = 32'd100;
                op_b      = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = i;
                    ghi = hi;
                    glo = lo;
                end
            end
            if (busy !== (i <= lat)) busy_bad++;
        end
        chk({name, ".latency"}, 64'(first_done), 64'(lat));
        chk({name, ".done_pulses"}, 64'(ndone), 64'd1);
        chk({name, ".busy_err"}, 64'(busy_bad), 64'd0);
        chk({name, ".result"}, {ghi, glo}, {exp_hi, exp_lo});
        chk({name, ".held"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    vec_t vecs[$];

    initial begin
        logic [63:0] p;
        bit          sgn;
        logic [31:0] a, b;
        int          stray;

        vecs.push_back('{"uns_ffxff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{"sgn_m3x5",  1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
        vecs.push_back('{"sgn_minxmin", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        vecs.push_back('{"sgn_0xmin", 1'b1, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000});
        vecs.push_back('{"sgn_minx1", 1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{"uns_minx2", 1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000});
        vecs.push_back('{"sgn_m1xm1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
        vecs.push_back('{"sgn_7xm6",  1'b1, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6});
        vecs.push_back('{"uns_x0",    1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000});

        // Reset state.
        #2;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.hilo", {hi, lo}, 64'd0);

        // Release reset and start on the very first edge afterwards.
        @(negedge clk);
        rst = 1'b0;
        run_op("first_after_rst", 1'b0, 32'd9, 32'd11, 32'd0, 32'd99, 0);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, 0);

        // Second start during a run must be ignored.
        run_op("restart_ignored", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 5);

        // Reset in the 10th ITER cycle of an unsigned run.
        start     = 1'b1;
        is_signed = 1'b0;
        op_a      = 32'h1234;
        op_b      = 32'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 10; i++) @(negedge clk);
        chk("pre_rst.busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst.busy", 64'(busy), 64'd0);
        chk("mid_rst.done", 64'(done), 64'd0);
        chk("mid_rst.hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        chk("post_rst.idle", 64'(stray), 64'd0);
        run_op("after_rst_10000sq", 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 0);

        // Random regression against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: b = 32'hFFFFFFFF;
                2: a = 32'($urandom_range(0, 15));
                default: ;
            endcase
            p = ref_prod(sgn, a, b);
            run_op($sformatf("rand%0d", n), sgn, a, b, p[63:32], p[31:0], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
